// File: rtl/fsm_requester.sv
// Client-side requester for the req/gnt arbiter protocol: accepts a burst command,
// holds req until the burst is granted or times out, then waits for gnt to drop.
module fsm_requester #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int GAP     = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             req,
  input  logic             gnt,
  output logic             beat,
  output logic             done,
  output logic             timeout_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_REL
  } state_t;

  localparam logic [7:0]       TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [3:0]       GAP_C     = 4'(GAP);
  localparam logic [LEN_W-1:0] ONE_BEAT  = LEN_W'(1);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic [7:0]       wait_cnt;
  logic [3:0]       gap_cnt;

  logic [LEN_W-1:0] beat_nxt;
  logic [7:0]       wait_nxt;
  logic [3:0]       gap_nxt;
  logic             last_beat;
  logic             wait_expire;
  logic             gap_expire;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    beat_nxt    = beat_cnt;
    wait_nxt    = wait_cnt + 8'd1;
    gap_nxt     = gap_cnt + 4'd1;
    last_beat   = 1'b0;
    wait_expire = 1'b0;
    gap_expire  = 1'b0;
    // Beat counter saturates at len rather than wrapping.
    if (beat_cnt != len_q) begin
      beat_nxt = beat_cnt + ONE_BEAT;
    end
    last_beat   = (beat_nxt == len_q);
    wait_expire = (wait_nxt == TIMEOUT_C);
    gap_expire  = (gap_nxt == GAP_C);
  end

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      len_q       <= ONE_BEAT;
      beat_cnt    <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      req         <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            len_q    <= (cmd_len == '0) ? ONE_BEAT : cmd_len;
            beat_cnt <= '0;
            wait_cnt <= '0;
            gap_cnt  <= '0;
            req      <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (gnt) begin
            beat_cnt <= beat_nxt;
            if (last_beat) begin
              req     <= 1'b0;
              done    <= 1'b1;
              gap_cnt <= '0;
              state   <= S_REL;
            end else begin
              state <= S_XFER;
            end
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_expire) begin
              req         <= 1'b0;
              timeout_err <= 1'b1;
              gap_cnt     <= '0;
              state       <= S_REL;
            end
          end
        end
        S_XFER: begin
          // A gnt=0 cycle here is a stall: nothing changes, req stays high.
          if (gnt) begin
            beat_cnt <= beat_nxt;
            if (last_beat) begin
              req     <= 1'b0;
              done    <= 1'b1;
              gap_cnt <= '0;
              state   <= S_REL;
            end
          end
        end
        S_REL: begin
          // Only an unbroken run of gnt=0 cycles releases the requester.
          if (gnt) begin
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_nxt;
            if (gap_expire) begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign beat      = req & gnt;
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_fsm_requester.sv
// Self-checking bench for fsm_requester: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the requester.
module tb_fsm_requester;

  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 15;
  localparam int GAP     = 1;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             gnt = 1'b0;
  logic             cmd_ready;
  logic             req;
  logic             beat;
  logic             done;
  logic             timeout_err;
  logic             busy;

  fsm_requester #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .req        (req),
    .gnt        (gnt),
    .beat       (beat),
    .done       (done),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: beats owed, ungranted cycles waited, quiet gnt run.
  bit m_req, m_cool, m_done, m_to;
  int m_owed, m_got, m_waited, m_quiet;
  int accepted = 0, discarded = 0;

  int  pulses = 0;
  int  mon_beats, mon_done, mon_to, mon_req_cycles;
  bit  check_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_idle();
    return !m_req && !m_cool;
  endfunction

  task automatic model_reset();
    if (m_req) discarded++;
    m_req = 0; m_cool = 0; m_done = 0; m_to = 0;
    m_owed = 0; m_got = 0; m_waited = 0; m_quiet = 0;
  endtask

  task automatic model_edge(input bit v, input int len, input bit g);
    m_done = 0;
    m_to   = 0;
    if (m_idle()) begin
      if (v) begin
        m_req    = 1;
        m_owed   = (len == 0) ? 1 : len;
        m_got    = 0;
        m_waited = 0;
        accepted++;
      end
    end else if (m_req) begin
      if (g) begin
        m_got++;
        m_owed--;
        if (m_owed == 0) begin
          m_req = 0; m_done = 1; m_cool = 1; m_quiet = 0;
        end
      end else if (m_got == 0) begin
        m_waited++;
        if (m_waited == TIMEOUT) begin
          m_req = 0; m_to = 1; m_cool = 1; m_quiet = 0;
        end
      end
    end else begin
      if (g) m_quiet = 0;
      else   m_quiet++;
      if (m_quiet == GAP) m_cool = 0;
    end
  endtask

  task automatic step(input bit v, input int len, input bit g);
    cmd_valid = v;
    cmd_len   = len[LEN_W-1:0];
    gnt       = g;
    @(posedge clock);
    if (reset_n) model_edge(v, len, g);
    #1;
  endtask

  task automatic clear_mon();
    mon_beats = 0; mon_done = 0; mon_to = 0; mon_req_cycles = 0;
  endtask

  // Compare process: outputs are sampled mid-cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge clock);
      if (check_en) begin
        check("req",         int'(req),         int'(m_req));
        check("done",        int'(done),        int'(m_done));
        check("timeout_err", int'(timeout_err), int'(m_to));
        check("busy",        int'(busy),        int'(!m_idle()));
        check("cmd_ready",   int'(cmd_ready),   int'(m_idle()));
        check("beat",        int'(beat),        int'(m_req & gnt));
        check("done_xor_to", int'(done & timeout_err), 0);
        if (beat) mon_beats++;
        if (done) mon_done++;
        if (timeout_err) mon_to++;
        if (req) mon_req_cycles++;
        if (done || timeout_err) pulses++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int pct;

  initial begin
    model_reset();
    clear_mon();
    repeat (3) @(posedge clock);
    #1;
    check("rst_low_req",  int'(req), 0);
    check("rst_low_busy", int'(busy), 0);
    reset_n  = 1'b1;
    check_en = 1'b1;
    check("rst_req",       int'(req), 0);
    check("rst_done",      int'(done), 0);
    check("rst_timeout",   int'(timeout_err), 0);
    check("rst_busy",      int'(busy), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    step(0, 0, 0);

    // 3-beat burst, grant arrives two cycles after req.
    clear_mon();
    step(1, 3, 0);
    check("a_req_up", int'(req), 1);
    step(0, 0, 0);
    step(0, 0, 0);
    repeat (3) step(0, 0, 1);
    check("a_req_fall", int'(req), 0);
    check("a_done",     int'(done), 1);
    step(0, 0, 1);
    check("a_done_once",   int'(done), 0);
    check("a_ready_early", int'(cmd_ready), 0);
    step(0, 0, 0);
    check("a_ready_back", int'(cmd_ready), 1);
    check("a_beats",      mon_beats, 3);
    check("a_done_count", mon_done, 1);

    // Stall mid-burst: gnt 1,1,0,0,1,1 for a 4-beat burst.
    clear_mon();
    step(1, 4, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, (i == 2 || i == 3) ? 1'b0 : 1'b1);
      if (i == 3) check("b_req_in_stall", int'(req), 1);
    end
    check("b_req_fall", int'(req), 0);
    check("b_done",     int'(done), 1);
    check("b_beats",    mon_beats, 4);
    check("b_no_to",    mon_to, 0);
    step(0, 0, 0);
    check("b_ready", int'(cmd_ready), 1);

    // Timeout with gnt held low.
    clear_mon();
    step(1, 2, 0);
    repeat (TIMEOUT) step(0, 0, 0);
    check("c_req_fall",   int'(req), 0);
    check("c_timeout",    int'(timeout_err), 1);
    check("c_req_cycles", mon_req_cycles, 15);
    step(0, 0, 0);
    check("c_ready",    int'(cmd_ready), 1);
    check("c_no_done",  mon_done, 0);
    check("c_to_count", mon_to, 1);

    // Zero length, then grant lingers three cycles after release.
    clear_mon();
    step(1, 0, 0);
    step(0, 0, 1);
    check("d_done", int'(done), 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      check("d_no_beat",  int'(beat), 0);
      check("d_not_ready", int'(cmd_ready), 0);
    end
    step(0, 0, 0);
    check("d_ready", int'(cmd_ready), 1);
    check("d_beats", mon_beats, 1);

    // Asynchronous reset in the middle of a 5-beat burst.
    clear_mon();
    step(1, 5, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    reset_n = 1'b0;
    #1;
    check("e_req_async", int'(req), 0);
    check("e_busy_async", int'(busy), 0);
    model_reset();
    step(0, 0, 0);
    reset_n = 1'b1;
    check("e_no_done", mon_done, 0);
    clear_mon();
    step(1, 1, 0);
    step(0, 0, 1);
    check("e_done", int'(done), 1);
    step(0, 0, 0);
    check("e_beats", mon_beats, 1);

    // Randomized traffic with phases of different grant density.
    for (int ph = 0; ph < 8; ph++) begin
      case ($urandom_range(0, 3))
        0:       pct = 0;
        1:       pct = 30;
        2:       pct = 70;
        default: pct = 100;
      endcase
      repeat (50) step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                       ($urandom_range(0, 99) < pct));
    end
    repeat (20) step(0, 0, 1);
    repeat (5) step(0, 0, 0);
    check("cmd_vs_pulses", pulses, accepted - discarded);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_requester.md
# fsm_requester

Client-side requester for the four-way `req_n`/`gnt_n` arbiter protocol. One instance drives one arbiter request line. It accepts a burst command from local logic, raises `req`, counts granted beats, and drops `req` when the burst completes or the grant never arrives. It then waits for `gnt` to fall before it accepts new work. Up to four instances sit in front of the arbiter, one per `req_0..req_3` line.

## Interface
- `LEN_W`, default 4: width of the burst-length field.
- `TIMEOUT`, default 15: maximum number of consecutive ungranted request cycles before the requester aborts. Legal range 1..255.
- `GAP`, default 1: minimum number of consecutive `gnt`=0 cycles after release before the next command is accepted. Legal range 1..15.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  a burst command is offered.
- `cmd_ready`  out  1  the block can accept a command.
- `cmd_len`  in  LEN_W  burst length in beats. 0 is treated as 1.
- `req`  out  1  request to the arbiter. Registered.
- `gnt`  in  1  grant from the arbiter.
- `beat`  out  1  combinational; equals `req & gnt`. One transfer beat.
- `done`  out  1  one-cycle pulse when a burst completes. Registered.
- `timeout_err`  out  1  one-cycle pulse when a request is aborted. Registered.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, REQ, XFER, REL.
- **IDLE**
  - `cmd_ready`=1.
  - When `cmd_valid`&`cmd_ready` is seen at a clock edge: latch `len` = max(`cmd_len`,1), clear the beat and wait counters, set `req`=1, and move to REQ.
- **REQ**
  - `req`=1.
  - If `gnt`=1, the cycle is a beat: the beat counter increments. If the count reaches `len`, go to REL; otherwise go to XFER.
  - If `gnt`=0, the wait counter increments. When it reaches `TIMEOUT`, drop `req`, pulse `timeout_err`, and go to REL.
- **XFER**
  - `req`=1.
  - Each `gnt`=1 cycle is one beat.
  - A `gnt`=0 cycle is a stall: no beat and no timeout; `req` stays high.
  - On the beat that reaches `len`, drop `req`, pulse `done`, and go to REL.
- **REL**
  - `req`=0.
  - A gap counter counts consecutive `gnt`=0 cycles. Any `gnt`=1 cycle clears it.
  - When the gap counter reaches `GAP`, go to IDLE.
  - `gnt`=1 while `req`=0 is not a beat (`beat`=0).
- **Counters**
  - Beat counter is LEN_W bits and saturates at `len`; it never wraps.
  - Wait counter is 8 bits. Gap counter is 4 bits.
- `done` and `timeout_err` are never high in the same cycle. Exactly one of them pulses per accepted command.
- **Simultaneous events**
  - `cmd_valid` is ignored outside IDLE.
  - The completing beat and a timeout cannot coincide, because a beat clears the REQ path.
- **Reset**
  - Asserting `reset_n` low in any state immediately forces IDLE.
  - All outputs go to reset values: `req`=0, `done`=0, `timeout_err`=0, `busy`=0, `cmd_ready`=1 after release, and all counters 0.
  - A burst in flight is discarded with no `done` pulse.

## Timing
- **Command to request:** `req` rises at the edge that accepts the command, so it is visible 1 cycle after the accepting handshake.
- **Beats:** a beat is counted at the edge where `req`&`gnt` is sampled high.
- **End of burst:** for a burst of N beats with `gnt` continuously high, `req` falls and `done` pulses at the edge that samples beat N. `done` is high for exactly the following cycle.
- **Timeout:** `req` stays high for exactly `TIMEOUT` ungranted cycles. `req` falls and `timeout_err` pulses on the same edge.
- **Next command:** `cmd_ready` returns no earlier than `GAP` cycles after `req` falls, plus any cycles during which `gnt` remained high. The arbiter's registered grant lags `req` by at least one cycle.
- `cmd_ready` and `busy` are combinational decodes of state.

## Test plan
- **Reset values:** hold `reset_n`=0, then release. Required: `req`=0, `done`=0, `timeout_err`=0, `busy`=0, `cmd_ready`=1.
- **3-beat burst:** `cmd_len`=3 accepted; `gnt` rises 2 cycles after `req` and stays high. Required:
  - `beat` is high for exactly 3 cycles.
  - `req` falls on the 3rd beat edge, with `done`=1 for one cycle.
  - With `gnt` falling 1 cycle later and `GAP`=1, `cmd_ready`=1 two cycles after `req` falls.
- **Stall mid-burst:** `cmd_len`=4, with `gnt` pattern 1,1,0,0,1,1. Required: 4 beats counted, `req` held high through the stall, `done` after the 6th `gnt` cycle, `timeout_err` never asserted.
- **Timeout:** `cmd_len`=2, `gnt` held 0, `TIMEOUT`=15. Required:
  - `req` is high for exactly 15 cycles, then falls with a one-cycle `timeout_err`.
  - No `done` pulse.
  - Return to IDLE after `GAP` cycles.
- **Zero length and late grant:** `cmd_len`=0. Required: treated as 1 beat. With `gnt` held high for 3 cycles after `req` drops, `beat` stays 0 and `cmd_ready` stays 0 until `gnt` has been low for `GAP` cycles.
- **Reset mid-burst:** pulse `reset_n` low during XFER after 2 of 5 beats. Required: `req` drops immediately without waiting for a clock edge, no `done` pulse, and a new `cmd_len`=1 command after release completes with exactly 1 beat.
